// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, tap index type and FSM state encoding for the FIR MAC engine
package fir_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int TAPS       = 64;
  localparam int FRAC_BITS  = 15;
  localparam int TAP_BITS   = $clog2(TAPS);
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + TAP_BITS;
  typedef logic [TAP_BITS-1:0] tap_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;
endpackage

// File: rtl/fir_mac_accum_if.sv
// fir_mac_accum_if: sample stream, coefficient fetch and result handshake of the FIR MAC engine
interface fir_mac_accum_if;
  import fir_pkg::*;
  logic                         frame_start;
  logic                         sample_valid;
  logic signed [DATA_WIDTH-1:0] sample_in;
  logic signed [DATA_WIDTH-1:0] coeff_in;
  tap_t                         coeff_addr;
  logic                         busy;
  logic                         overrun;
  logic signed [DATA_WIDTH-1:0] y_data;
  logic                         y_sat;
  logic                         y_valid;
  logic                         y_ready;
  modport master (
    output frame_start, sample_valid, sample_in, coeff_in, y_ready,
    input  coeff_addr, busy, overrun, y_data, y_sat, y_valid
  );
  modport slave (
    input  frame_start, sample_valid, sample_in, coeff_in, y_ready,
    output coeff_addr, busy, overrun, y_data, y_sat, y_valid
  );
endinterface

// File: rtl/fir_round_sat.sv
// fir_round_sat: round-half-up Q-format accumulator to DATA_WIDTH and clamp, flagging saturation
module fir_round_sat
  import fir_pkg::*;
(
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         sat
);
  localparam logic signed [DATA_WIDTH-1:0] Y_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] Y_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH:0] sum, q;
  logic hi, lo;
  // one guard bit keeps the rounding add from wrapping
  assign sum = {acc[ACC_WIDTH-1], acc} + (ACC_WIDTH+1)'(2 ** (FRAC_BITS - 1));
  assign q   = sum >>> FRAC_BITS;
  assign hi  = q > (ACC_WIDTH+1)'(Y_MAX);
  assign lo  = q < (ACC_WIDTH+1)'(Y_MIN);
  assign sat = hi | lo;
  assign y   = hi ? Y_MAX : lo ? Y_MIN : q[DATA_WIDTH-1:0];
endmodule

// File: rtl/fir_mac_accum.sv
// fir_mac_accum: two-stage multiply-accumulate over one 64-tap frame, rounded and saturated
// to a single sample presented on a valid/ready port
module fir_mac_accum
  import fir_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  fir_mac_accum_if.slave bus
);
  state_t state, state_nx;
  tap_t tap;
  logic drain, acc_en, accept, last, done, hs, sat_rs;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [DATA_WIDTH-1:0]   y_rs;
  assign accept         = state == ACCUM && bus.sample_valid;
  assign last           = accept && tap == tap_t'(TAPS - 1);
  assign done           = state == DRAIN && drain;
  assign hs             = state == OUTPUT && bus.y_valid && bus.y_ready;
  assign bus.coeff_addr = tap;
  assign bus.busy       = state != IDLE;
  fir_round_sat u_round_sat (.acc(acc), .y(y_rs), .sat(sat_rs));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && bus.frame_start) ? ACCUM :
               last ? DRAIN :
               done ? OUTPUT :
               hs   ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      tap         <= '0;
      prod        <= '0;
      acc         <= '0;
      acc_en      <= 1'b0;
      drain       <= 1'b0;
      bus.overrun <= 1'b0;
      bus.y_data  <= '0;
      bus.y_sat   <= 1'b0;
      bus.y_valid <= 1'b0;
    end else begin
      bus.overrun <= bus.frame_start && state != IDLE;
      acc_en      <= accept;
      drain       <= state == DRAIN && !drain;
      if (state == IDLE && bus.frame_start) begin
        tap  <= '0;
        prod <= '0;
        acc  <= '0;
      end else begin
        if (accept) begin
          prod <= bus.sample_in * bus.coeff_in;
          tap  <= tap + tap_t'(1);
        end
        // second stage consumes the product registered on the previous accept
        if (acc_en) acc <= acc + ACC_WIDTH'(prod);
      end
      if (done) begin
        bus.y_data  <= y_rs;
        bus.y_sat   <= sat_rs;
        bus.y_valid <= 1'b1;
      end else if (hs) bus.y_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fir_mac_accum.sv
// tb_fir_mac_accum: directed and randomized frames against a plain-arithmetic FIR reference model
module tb_fir_mac_accum;
  import fir_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  logic signed [15:0] smp[TAPS];
  logic signed [15:0] cf[TAPS];
  fir_mac_accum_if bus();
  fir_mac_accum dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  assign bus.coeff_in = cf[bus.coeff_addr];

  task automatic ref_model(output logic signed [15:0] ey, output logic es);
    longint s;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(smp[k]) * longint'(cf[k]);
    s = (s + 64'sd16384) >>> 15;
    es = s > 32767 || s < -32768;
    ey = s > 32767 ? 16'sh7fff : s < -32768 ? 16'sh8000 : 16'(s);
  endtask

  task automatic fill_rand(input int cmag);
    for (int k = 0; k < TAPS; k++) begin
      smp[k] = 16'($urandom);
      cf[k]  = 16'(int'($urandom_range(2 * cmag)) - cmag);
    end
  endtask

  task automatic fill_const(input logic signed [15:0] s0, input logic signed [15:0] c0, input bit only_tap0);
    for (int k = 0; k < TAPS; k++) begin
      smp[k] = (only_tap0 && k != 0) ? 16'sd0 : s0;
      cf[k]  = (only_tap0 && k != 0) ? 16'($urandom) : c0;
    end
  endtask

  task automatic start_frame();
    bus.sample_valid = 1'b1;
    bus.sample_in    = 16'($urandom);
    bus.frame_start  = 1'b1;
    @(negedge clk);
    bus.frame_start  = 1'b0;
    bus.sample_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b exp=1", bus.busy); end
  endtask

  task automatic feed(input int gap_pct, input int ntaps, input int ovr_tap);
    for (int k = 0; k < ntaps; k++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        bus.sample_valid = 1'b0;
        bus.sample_in    = 16'($urandom);
        @(negedge clk);
      end
      total++;
      if (bus.coeff_addr !== tap_t'(k)) begin
        bad++; $display("FAIL coeff_addr got=%0d exp=%0d", bus.coeff_addr, k);
      end
      bus.sample_in    = smp[k];
      bus.sample_valid = 1'b1;
      bus.frame_start  = (k == ovr_tap);
      @(negedge clk);
      bus.frame_start  = 1'b0;
      if (k == ovr_tap) begin
        total++;
        if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_accum got=%b exp=1", bus.overrun); end
      end
    end
    bus.sample_valid = 1'b0;
  endtask

  // n counts edges after the accepting edge of the last tap; y_valid is due on the second
  task automatic finish_frame(input logic signed [15:0] ey, input logic es, input int exp_lat,
                              input int hold, input bit ovr_drain, input bit ovr_out);
    int n;
    n = 0;
    if (ovr_drain) begin
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      n = 1;
      total++;
      if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_drain got=%b exp=1", bus.overrun); end
    end
    while (bus.y_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (bus.y_valid !== 1'b1) begin bad++; $display("FAIL y_valid_timeout got=%b exp=1", bus.y_valid); end
    if (exp_lat >= 0) begin
      total++;
      if (n != exp_lat) begin bad++; $display("FAIL latency got=%0d exp=%0d", n, exp_lat); end
    end
    total++;
    if (bus.y_data !== ey || bus.y_sat !== es) begin
      bad++; $display("FAIL result got=%0d/%b exp=%0d/%b", bus.y_data, bus.y_sat, ey, es);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (bus.y_valid !== 1'b1 || bus.y_data !== ey || bus.y_sat !== es) begin
        bad++; $display("FAIL hold got=%b/%0d/%b exp=1/%0d/%b", bus.y_valid, bus.y_data, bus.y_sat, ey, es);
      end
    end
    bus.y_ready     = 1'b1;
    bus.frame_start = ovr_out;
    @(negedge clk);
    bus.y_ready     = 1'b0;
    bus.frame_start = 1'b0;
    total++;
    if (bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL handshake got=%b/%b exp=0/0", bus.y_valid, bus.busy);
    end
    if (ovr_out) begin
      total++;
      if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_output got=%b exp=1", bus.overrun); end
      @(negedge clk);
      total++;
      if (bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL overrun_clear got=%b/%b exp=0/0", bus.overrun, bus.busy);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if (bus.busy !== 1'b0 || bus.overrun !== 1'b0 || bus.y_valid !== 1'b0 || bus.y_sat !== 1'b0 ||
        bus.y_data !== 16'sd0 || bus.coeff_addr !== 6'd0) begin
      bad++;
      $display("FAIL %s got=busy%b ovr%b vld%b sat%b y%0d addr%0d exp=all zero", tag, bus.busy,
               bus.overrun, bus.y_valid, bus.y_sat, bus.y_data, bus.coeff_addr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_reset_vals("reset_state");
    rstn = 1'b1;
    @(negedge clk);
    check_reset_vals("after_reset");
  endtask

  task automatic test_impulse();
    fill_const(16'sd1000, 16'sd16384, 1'b1);
    start_frame(); feed(0, TAPS, -1); finish_frame(16'sd500, 1'b0, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_rounding();
    fill_const(-16'sd3, 16'sd16384, 1'b1);
    start_frame(); feed(0, TAPS, -1); finish_frame(-16'sd1, 1'b0, 2, 0, 1'b0, 1'b0);
    fill_const(16'sd3, 16'sd16384, 1'b1);
    start_frame(); feed(0, TAPS, -1); finish_frame(16'sd2, 1'b0, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    fill_const(16'sd32767, 16'sd32767, 1'b0);
    start_frame(); feed(0, TAPS, -1); finish_frame(16'sh7fff, 1'b1, 2, 0, 1'b0, 1'b0);
    fill_const(-16'sd32768, 16'sd32767, 1'b0);
    start_frame(); feed(0, TAPS, -1); finish_frame(16'sh8000, 1'b1, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps_backpressure();
    logic signed [15:0] ey;
    logic es;
    for (int f = 0; f < 5; f++) begin
      fill_rand(f == 4 ? 32767 : 600);
      ref_model(ey, es);
      start_frame(); feed(30, TAPS, -1); finish_frame(ey, es, -1, 10, 1'b0, 1'b0);
    end
  endtask

  task automatic test_overrun();
    logic signed [15:0] ey;
    logic es;
    fill_rand(800);
    ref_model(ey, es);
    start_frame(); feed(0, TAPS, 20); finish_frame(ey, es, 2, 3, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    logic signed [15:0] ey;
    logic es;
    fill_rand(800);
    start_frame(); feed(20, 30, -1);
    rstn = 1'b0;
    #1;
    check_reset_vals("reset_mid_frame");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_reset_vals("after_abort");
    fill_rand(800);
    ref_model(ey, es);
    start_frame(); feed(0, TAPS, -1); finish_frame(ey, es, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] ey;
    logic es;
    for (int f = 0; f < 2; f++) begin
      fill_rand(700);
      ref_model(ey, es);
      start_frame(); feed(0, TAPS, -1); finish_frame(ey, es, 2, 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_start  = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.y_ready      = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_gaps_backpressure();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
